ex_decim_acc: RTL and testbench

Parametrised multi-channel decimating accumulator, the next generation of the single-channel `ce`-qualified capture blocks in the example HDL set. It accepts one signed sample per `ce` strobe, tagged with a channel index, and sums `DECIM` samples per channel. It then emits one scaled, width-converted result with a one-cycle `data_valid` pulse. It sits between a sample source (ADC front end or test generator) and downstream processing, and adds channel interleaving, decimation, arithmetic scaling and selectable saturation.

---
 rtl/ex_pkg.sv | 25 ++
 rtl/ex_shift_sat.sv | 34 +++
 rtl/ex_decim_acc.sv | 101 ++++++++++
 tb/tb_ex_decim_acc.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared helpers for the decimating accumulator family
//   clog2          - ceiling log2 of a positive integer (clog2(1) = 0)
//   ch_w           - index width for n entries, never less than 1
//   acc_w          - accumulator width: sample width plus growth for decim samples
//   SAT_WRAP/CLAMP - encodings of the SAT_MODE parameter
package ex_pkg;
    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((32'sd1 <<< i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int acc_w(input int data_w, input int decim);
        return data_w + clog2(decim);
    endfunction
endpackage

// File: rtl/ex_shift_sat.sv
// ex_shift_sat: combinational arithmetic right shift followed by saturate or wrap
//   din  - signed IN_W value to scale
//   dout - signed OUT_W result (floor shift, then clamp or keep low bits)
//   ovf  - result did not fit OUT_W and was clamped or wrapped
module ex_shift_sat
    import ex_pkg::*;
#(
    parameter int IN_W     = 34,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0,
    parameter int SAT_MODE = SAT_CLAMP
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);
    logic signed [IN_W-1:0] r;
    assign r = din >>> SHIFT;
    if (OUT_W >= IN_W) begin : g_ext
        assign dout = OUT_W'(r);
        assign ovf  = 1'b0;
    end else begin : g_nar
        logic fits;
        // value fits when every bit from the output sign bit upward equals the sign
        assign fits = r[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){r[IN_W-1]}};
        assign ovf  = !fits;
        if (SAT_MODE == SAT_CLAMP) begin : g_clamp
            // negative overflow -> 100..0, positive overflow -> 011..1
            assign dout = fits ? r[OUT_W-1:0] : {r[IN_W-1], {(OUT_W-1){!r[IN_W-1]}}};
        end else begin : g_wrap
            assign dout = r[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/ex_decim_acc.sv
// ex_decim_acc: multi-channel decimating accumulator with scaled, saturating or wrapping output
//   clk, rst      - rising-edge clock, asynchronous active-low reset
//   data_in, ce   - signed sample, taken on the edge where ce=1
//   ch_id         - channel of the sample; ids >= CHANNELS are ignored
//   clear         - synchronous clear of all partial sums (same-cycle sample dropped)
//   data_valid    - one-cycle strobe for each completed block of DECIM samples
//   data_out      - scaled block sum, held between strobes
//   data_ch       - channel of data_out, held between strobes
//   overflow      - with data_valid: the result was clamped or wrapped
module ex_decim_acc
    import ex_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  OUT_W    = 32,
    parameter int  CHANNELS = 4,
    parameter int  DECIM    = 8,
    parameter int  SHIFT    = 3,
    parameter int  SAT_MODE = SAT_CLAMP,
    localparam int CH_W     = ch_w(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     ce,
    input  logic [CH_W-1:0]          ch_id,
    input  logic                     clear,
    output logic                     data_valid,
    output logic signed [OUT_W-1:0]  data_out,
    output logic [CH_W-1:0]          data_ch,
    output logic                     overflow
);
    localparam int ACC_W = acc_w(DATA_W, DECIM);
    localparam int CNT_W = ch_w(DECIM);

    logic signed [ACC_W-1:0] acc [CHANNELS];
    logic [CNT_W-1:0]        cnt [CHANNELS];
    logic signed [ACC_W-1:0] sum, sum_q;
    logic [CH_W-1:0]         ch_q;
    logic                    hit, last, done_q, ovf;
    logic signed [OUT_W-1:0] res;

    assign hit  = ce && !clear && (32'(ch_id) < CHANNELS);
    assign sum  = acc[ch_id] + ACC_W'(data_in);
    assign last = 32'(cnt[ch_id]) == DECIM - 1;

    // accumulate; a completing sample hands its sum to the output pipeline stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
            done_q <= 1'b0;
            sum_q  <= '0;
            ch_q   <= '0;
        end else begin
            done_q <= hit && last;
            if (hit && last) begin
                sum_q <= sum;
                ch_q  <= ch_id;
            end
            if (clear) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    acc[c] <= '0;
                    cnt[c] <= '0;
                end
            end else if (hit) begin
                acc[ch_id] <= last ? '0 : sum;
                cnt[ch_id] <= last ? '0 : cnt[ch_id] + 1'b1;
            end
        end
    end

    ex_shift_sat #(
        .IN_W    (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .SAT_MODE(SAT_MODE)
    ) u_shift_sat (
        .din (sum_q),
        .dout(res),
        .ovf (ovf)
    );

    // result register: data_out/data_ch hold, strobe and overflow drop back to 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid <= 1'b0;
            data_out   <= '0;
            data_ch    <= '0;
            overflow   <= 1'b0;
        end else begin
            data_valid <= done_q;
            overflow   <= done_q && ovf;
            if (done_q) begin
                data_out <= res;
                data_ch  <= ch_q;
            end
        end
    end
endmodule

// File: tb/tb_ex_decim_acc.sv
// tb_ex_decim_acc: scoreboard bench, four configurations driven by one stimulus stream
module tb_ex_decim_acc;
    logic        clk = 0, rst = 0, ce = 0, clear = 0, ce4;
    logic [31:0] data_in = 0;
    logic [2:0]  ch = 0;
    wire  [3:0]  v, ov;
    wire  [15:0] dout [4];
    wire  [1:0]  dch [3];
    wire  [2:0]  dch5;
    longint      cyc = 0;
    int          checks = 0, errors = 0;
    int          sh [4] = '{2, 0, 0, 2};
    bit          st [4] = '{1, 1, 0, 1};

    typedef struct {longint cyc; int ch; longint sum;} exp_t;
    exp_t   q [$];
    exp_t   e;
    longint macc [4];
    int     mcnt [4];
    longint mo;
    bit     mf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 4-channel instances only see in-range ids; the 5-channel one sees ids 5..7 as out of range
    assign ce4 = ce && !ch[2];

    ex_decim_acc #(.DATA_W(32), .OUT_W(16), .CHANNELS(4), .DECIM(4), .SHIFT(2), .SAT_MODE(1)) u0 (
        .clk(clk), .rst(rst), .data_in(data_in), .ce(ce4), .ch_id(ch[1:0]), .clear(clear),
        .data_valid(v[0]), .data_out(dout[0]), .data_ch(dch[0]), .overflow(ov[0]));
    ex_decim_acc #(.DATA_W(32), .OUT_W(16), .CHANNELS(4), .DECIM(4), .SHIFT(0), .SAT_MODE(1)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .ce(ce4), .ch_id(ch[1:0]), .clear(clear),
        .data_valid(v[1]), .data_out(dout[1]), .data_ch(dch[1]), .overflow(ov[1]));
    ex_decim_acc #(.DATA_W(32), .OUT_W(16), .CHANNELS(4), .DECIM(4), .SHIFT(0), .SAT_MODE(0)) u2 (
        .clk(clk), .rst(rst), .data_in(data_in), .ce(ce4), .ch_id(ch[1:0]), .clear(clear),
        .data_valid(v[2]), .data_out(dout[2]), .data_ch(dch[2]), .overflow(ov[2]));
    ex_decim_acc #(.DATA_W(32), .OUT_W(16), .CHANNELS(5), .DECIM(4), .SHIFT(2), .SAT_MODE(1)) u3 (
        .clk(clk), .rst(rst), .data_in(data_in), .ce(ce), .ch_id(ch), .clear(clear),
        .data_valid(v[3]), .data_out(dout[3]), .data_ch(dch5), .overflow(ov[3]));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference scaling: floor divide by 2^shift, then clamp or wrap to 16 bits
    function automatic void calc(input longint s, input int shv, input bit sat,
                                 output longint o, output bit f);
        longint r;
        r = s >>> shv;
        if (sat) o = (r > 32767) ? 64'sd32767 : (r < -32768) ? -64'sd32768 : r;
        else     o = longint'(shortint'(r));
        f = o != r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            macc[c] = 0;
            mcnt[c] = 0;
        end
    endtask

    task automatic send(input int c, input int d, input bit clr = 0);
        ce = 1; ch = 3'(c); data_in = d; clear = clr;
        if (clr) model_clear();
        else if (c < 4) begin
            macc[c] += d;
            mcnt[c]++;
            if (mcnt[c] == 4) begin
                q.push_back('{cyc + 2, c, macc[c]});
                macc[c] = 0;
                mcnt[c] = 0;
            end
        end
        tick();
        ce = 0; clear = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("drain_pending", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (|v) begin
            if (v != 4'hF || q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid: got %b with %0d pending, expected 1111 with a pending result", v, q.size());
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.cyc);
                for (int k = 0; k < 4; k++) begin
                    calc(e.sum, sh[k], st[k], mo, mf);
                    chk($sformatf("data_out[%0d]", k), longint'($signed(dout[k])), mo);
                    chk($sformatf("overflow[%0d]", k), longint'(ov[k]), longint'(mf));
                end
                for (int k = 0; k < 3; k++) chk($sformatf("data_ch[%0d]", k), longint'(dch[k]), e.ch);
                chk("data_ch[3]", longint'(dch5), e.ch);
            end
        end else chk("idle_overflow", longint'(ov), 0);
    end

    initial begin
        model_clear();
        repeat (2) tick();
        chk("rst_valid", longint'(v), 0);
        chk("rst_data_out", longint'(dout[0]), 0);
        chk("rst_data_ch", longint'(dch[0]), 0);
        rst = 1;
        tick();
        // basic block and floor rounding of a negative sum
        send(0, 100); send(0, 200); send(0, 300); send(0, 400);
        tick();
        send(1, -1); send(1, -1); send(1, -1); send(1, -2);
        drain();
        // full-scale positive sums: clamp and wrap
        repeat (4) send(2, 32'h7FFFFFFF);
        drain();
        // interleaved channels with an out-of-range id in the middle
        send(0, 8); send(3, -8); send(0, 8); send(3, -8);
        send(5, 12345);
        send(0, 8); send(3, -8); send(0, 8); send(3, -8);
        drain();
        // clear drops partial sums and the sample presented with it
        send(0, 7); send(0, 9); send(0, 1000, 1);
        repeat (4) send(0, 40);
        drain();
        // asynchronous reset in the middle of a block
        send(0, 11); send(0, 22); send(0, 33);
        #2 rst = 0;
        #1;
        chk("arst_valid", longint'(v), 0);
        chk("arst_overflow", longint'(ov), 0);
        for (int k = 0; k < 4; k++) chk($sformatf("arst_data_out[%0d]", k), longint'(dout[k]), 0);
        chk("arst_data_ch", longint'(dch5), 0);
        model_clear();
        tick(); tick();
        rst = 1;
        tick();
        repeat (4) send(0, 4);
        drain();
        // randomized interleaving, magnitudes and occasional clears
        for (int i = 0; i < 400; i++) begin
            int c, d;
            c = $urandom_range(0, 6);
            if (c >= 4) c++;
            d = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            if ($urandom_range(0, 4) == 0) tick();
            else send(c, d, $urandom_range(0, 39) == 0);
        end
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
